// File: rtl/mc_defs_pkg.sv
// Shared memory-controller definitions: DRAM command codes, scheduler states,
// default refresh timing and the per-state output decode.
package mc_defs_pkg;

  localparam int unsigned T_RP_DEF  = 3;
  localparam int unsigned T_RFC_DEF = 35;
  localparam int unsigned CMD_W     = 2;
  localparam int unsigned RCNT_W    = 16;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP  = 2'd0,
    CMD_PREA = 2'd1,
    CMD_REF  = 2'd2
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOST     = 3'd1,
    ST_PRECH    = 3'd2,
    ST_WAIT_RP  = 3'd3,
    ST_REF      = 3'd4,
    ST_WAIT_RFC = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  typedef struct packed {
    logic host_gnt;
    logic cmd_valid;
    cmd_e cmd;
    logic refreshed;
    logic busy;
  } sched_out_t;

  // Moore output decode for a scheduler state
  function automatic sched_out_t state_outs(state_e st);
    sched_out_t o;
    o.host_gnt  = 1'b0;
    o.cmd_valid = 1'b0;
    o.cmd       = CMD_NOP;
    o.refreshed = 1'b0;
    o.busy      = (st != ST_IDLE);
    case (st)
      ST_HOST:  o.host_gnt = 1'b1;
      ST_PRECH: begin
        o.cmd_valid = 1'b1;
        o.cmd       = CMD_PREA;
      end
      ST_REF: begin
        o.cmd_valid = 1'b1;
        o.cmd       = CMD_REF;
      end
      ST_DONE:  o.refreshed = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Loadable down-counter that stops at zero; shared by refresh and host timing.
module wait_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // Load has priority; otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/refresh_scheduler.sv
// DRAM refresh sequencer: arbitrates the command bus between the host path and
// refresh, then issues PREA and REF with tRP/tRFC spacing.
module refresh_scheduler
  import mc_defs_pkg::*;
#(
  parameter int unsigned T_RP  = T_RP_DEF,
  parameter int unsigned T_RFC = T_RFC_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              refresh,
  input  logic              host_req,
  input  logic              host_done,
  output logic              host_gnt,
  output logic              cmd_valid,
  output logic [CMD_W-1:0]  cmd,
  input  logic              cmd_ack,
  output logic              refreshed,
  output logic              busy,
  output logic [RCNT_W-1:0] refresh_count
);

  state_e            state_q;
  sched_out_t        out_q;
  logic [RCNT_W-1:0] refresh_count_q;

  logic              timer_load_c;
  logic [CNT_W-1:0]  timer_val_c;
  logic              timer_zero;

  // The wait counter is loaded on the ack cycle of PREA or REF
  assign timer_load_c = cmd_ack && ((state_q == ST_PRECH) || (state_q == ST_REF));
  assign timer_val_c  = (state_q == ST_PRECH) ? CNT_W'(T_RP - 1) : CNT_W'(T_RFC - 1);

  wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load_c),
    .load_val (timer_val_c),
    .zero     (timer_zero)
  );

  // Scheduler FSM; outputs are registered as the decode of the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      out_q           <= state_outs(ST_IDLE);
      refresh_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (refresh) begin
            state_q <= ST_PRECH;
            out_q   <= state_outs(ST_PRECH);
          end else if (host_req) begin
            state_q <= ST_HOST;
            out_q   <= state_outs(ST_HOST);
          end
        end
        ST_HOST: begin
          if (host_done) begin
            if (refresh) begin
              state_q <= ST_PRECH;
              out_q   <= state_outs(ST_PRECH);
            end else begin
              state_q <= ST_IDLE;
              out_q   <= state_outs(ST_IDLE);
            end
          end
        end
        ST_PRECH: begin
          if (cmd_ack) begin
            state_q <= ST_WAIT_RP;
            out_q   <= state_outs(ST_WAIT_RP);
          end
        end
        ST_WAIT_RP: begin
          if (timer_zero) begin
            state_q <= ST_REF;
            out_q   <= state_outs(ST_REF);
          end
        end
        ST_REF: begin
          if (cmd_ack) begin
            state_q <= ST_WAIT_RFC;
            out_q   <= state_outs(ST_WAIT_RFC);
          end
        end
        ST_WAIT_RFC: begin
          if (timer_zero) begin
            state_q <= ST_DONE;
            out_q   <= state_outs(ST_DONE);
          end
        end
        ST_DONE: begin
          state_q         <= ST_IDLE;
          out_q           <= state_outs(ST_IDLE);
          refresh_count_q <= refresh_count_q + RCNT_W'(1);
        end
        default: begin
          state_q <= ST_IDLE;
          out_q   <= state_outs(ST_IDLE);
        end
      endcase
    end
  end

  assign host_gnt      = out_q.host_gnt;
  assign cmd_valid     = out_q.cmd_valid;
  assign cmd           = out_q.cmd;
  assign refreshed     = out_q.refreshed;
  assign busy          = out_q.busy;
  assign refresh_count = refresh_count_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler: expected per-cycle waveforms are assembled from
// segment lengths (host access, ack stalls, tRP, tRFC) and compared cycle by cycle.
module tb_refresh_scheduler;

  localparam int unsigned T_RP  = 2;
  localparam int unsigned T_RFC = 5;
  localparam int unsigned CNT_W = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        refresh;
  logic        host_req;
  logic        host_done;
  logic        cmd_ack;
  logic        host_gnt;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        refreshed;
  logic        busy;
  logic [15:0] refresh_count;

  typedef struct packed {
    logic        gnt;
    logic        vld;
    logic [1:0]  cmd;
    logic        rfd;
    logic        busy;
    logic [15:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  logic [3:0]  stim_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [15:0] mcount;

  always #5 clk = ~clk;

  refresh_scheduler #(
    .T_RP  (T_RP),
    .T_RFC (T_RFC),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .refresh       (refresh),
    .host_req      (host_req),
    .host_done     (host_done),
    .host_gnt      (host_gnt),
    .cmd_valid     (cmd_valid),
    .cmd           (cmd),
    .cmd_ack       (cmd_ack),
    .refreshed     (refreshed),
    .busy          (busy),
    .refresh_count (refresh_count)
  );

  function automatic obs_t mk(logic g, logic v, logic [1:0] c, logic rf, logic b);
    obs_t e;
    e.gnt  = g;
    e.vld  = v;
    e.cmd  = c;
    e.rfd  = rf;
    e.busy = b;
    e.cnt  = mcount;
    return e;
  endfunction

  function automatic obs_t e_idle(); return mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0); endfunction
  function automatic obs_t e_host(); return mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1); endfunction
  function automatic obs_t e_prea(); return mk(1'b0, 1'b1, 2'd1, 1'b0, 1'b1); endfunction
  function automatic obs_t e_wait(); return mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1); endfunction
  function automatic obs_t e_ref();  return mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b1); endfunction
  function automatic obs_t e_done(); return mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b1); endfunction

  function automatic logic junk();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {host_gnt, cmd_valid, cmd, refreshed, busy, refresh_count};
    return o;
  endfunction

  task automatic check(input string tag, input int cyc, input obs_t o, input obs_t e);
    checks++;
    assert (o === e) passes++;
    else $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, o, e);
  endtask

  // One cycle of expectation plus the inputs driven during that cycle
  task automatic push(input obs_t e, input logic hreq, input logic rf,
                      input logic hd, input logic ak);
    exp_q.push_back(e);
    stim_q.push_back({hreq, rf, hd, ak});
  endtask

  task automatic run_q(input string tag);
    obs_t       e;
    logic [3:0] s;
    int         i;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      {host_req, refresh, host_done, cmd_ack} = s;
      check(tag, i, observe(), e);
      @(posedge clk);
      @(negedge clk);
      i++;
    end
  endtask

  // Host access of hl grant cycles, requested from an idle cycle
  task automatic build_host(input int hl);
    push(e_idle(), 1'b1, 1'b0, junk(), junk());
    for (int k = 1; k <= hl; k++) push(e_host(), 1'b1, 1'b0, 1'(k == hl), junk());
  endtask

  // Refresh sequence: optional host access first (hl>0), optional simultaneous host
  // request (both), p/r ack stall cycles, optional truncation inside tRFC
  task automatic build_seq(input int hl, input bit both, input int p, input int r,
                           input int stop_rfc);
    if (hl > 0) begin
      push(e_idle(), 1'b1, 1'b0, junk(), junk());
      for (int k = 1; k <= hl; k++) push(e_host(), 1'b0, 1'b1, 1'(k == hl), junk());
    end else begin
      push(e_idle(), both, 1'b1, junk(), junk());
    end
    for (int j = 0; j <= p; j++) push(e_prea(), both, 1'b1, junk(), 1'(j == p));
    for (int j = 0; j < int'(T_RP); j++) push(e_wait(), both, 1'b1, junk(), junk());
    for (int j = 0; j <= r; j++) push(e_ref(), both, 1'b1, junk(), 1'(j == r));
    for (int j = 0; j < int'(T_RFC); j++) begin
      if (stop_rfc >= 0 && j == stop_rfc) return;
      push(e_wait(), both, 1'b1, junk(), junk());
    end
    push(e_done(), both, 1'b1, junk(), junk());
    mcount = mcount + 16'd1;
    if (both) begin
      push(e_idle(), 1'b1, 1'b0, junk(), junk());
      push(e_host(), 1'b0, 1'b0, 1'b1, junk());
    end
    push(e_idle(), 1'b0, 1'b0, junk(), junk());
  endtask

  initial begin
    reset     = 1'b1;
    refresh   = 1'b0;
    host_req  = 1'b0;
    host_done = 1'b0;
    cmd_ack   = 1'b0;
    mcount    = 16'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset", 0, observe(), e_idle());
    reset = 1'b0;

    push(e_idle(), 1'b0, 1'b0, 1'b0, 1'b0);
    push(e_idle(), 1'b0, 1'b0, 1'b0, 1'b0);
    run_q("idle");

    build_seq(0, 1'b0, 0, 0, -1);
    run_q("basic");

    build_seq(11, 1'b0, 0, 0, -1);
    run_q("host_hold");

    build_seq(0, 1'b1, 0, 0, -1);
    run_q("req_and_refresh");

    build_seq(0, 1'b0, 4, 0, -1);
    run_q("prea_stall");

    build_seq(0, 1'b0, 0, 3, -1);
    run_q("ref_stall");

    build_host(3);
    build_host(1);
    push(e_idle(), 1'b0, 1'b0, 1'b0, 1'b0);
    run_q("host_b2b");

    // Reset two cycles into tRFC, tracker also resets its request
    build_seq(0, 1'b0, 0, 0, 2);
    run_q("pre_reset");
    reset   = 1'b1;
    refresh = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mcount = 16'd0;
    check("mid_reset", 0, observe(), e_idle());
    for (int k = 0; k < 10; k++) push(e_idle(), 1'b0, 1'b0, junk(), junk());
    run_q("after_reset");

    // Preload the counter just below wrap
    force dut.refresh_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.refresh_count_q;
    mcount = 16'hFFFF;
    push(e_idle(), 1'b0, 1'b0, 1'b0, 1'b0);
    run_q("preload");
    build_seq(0, 1'b0, 0, 0, -1);
    run_q("wrap");

    for (int it = 0; it < 30; it++) begin
      int hl;
      bit both;
      if ($urandom_range(0, 3) == 0) begin
        build_host(int'($urandom_range(1, 5)));
        push(e_idle(), 1'b0, 1'b0, junk(), junk());
      end
      hl   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
      both = (hl == 0) && ($urandom_range(0, 1) == 1);
      build_seq(hl, both, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        push(e_idle(), 1'b0, 1'b0, junk(), junk());
      run_q("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
